// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcodes, mux encodings and control bundle for the pipe control unit
// Purpose: common definitions imported by pipe_decode and pipe_ctrl_unit.
// Contents: RV32I opcode constants, writeback/B-operand mux encodings,
//           the per-stage control bundle ctrl_t and its BUBBLE value.
package pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] REWR_NONE = 2'b00;
  localparam logic [1:0] REWR_MEM  = 2'b01;
  localparam logic [1:0] REWR_ALU  = 2'b10;

  localparam logic [1:0] BMUX_IMM  = 2'b00;
  localparam logic [1:0] BMUX_FOUR = 2'b01;
  localparam logic [1:0] BMUX_RS2  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [6:0] alu_op;
    logic       amux;
    logic [1:0] bmux;
    logic       is_jalr;
    logic       wen;
    logic [3:0] be;
    logic       rf_we;
    logic [1:0] rewr;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    valid:   1'b0,
    alu_op:  7'd0,
    amux:    1'b0,
    bmux:    BMUX_IMM,
    is_jalr: 1'b0,
    wen:     1'b1,
    be:      4'd0,
    rf_we:   1'b0,
    rewr:    REWR_NONE
  };

endpackage

// File: rtl/pipe_decode.sv
// rtl/pipe_decode.sv - combinational opcode decoder for the pipe control unit
// Purpose: map an ID-stage opcode to its control bundle and source-register usage.
// Ports:
//   opcode_i    in  7  ID opcode
//   ctrl_o      out    decoded control bundle (BUBBLE for unknown opcodes)
//   uses_rs1_o  out 1  instruction reads rs1
//   uses_rs2_o  out 1  instruction reads rs2
module pipe_decode
  import pipe_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    ctrl_o     = BUBBLE;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        ctrl_o.valid = 1'b1; ctrl_o.alu_op = opcode_i;
        ctrl_o.rf_we = 1'b1; ctrl_o.rewr = REWR_ALU;
        ctrl_o.amux  = 1'b1; ctrl_o.bmux = BMUX_RS2;
        uses_rs1_o   = 1'b1; uses_rs2_o  = 1'b1;
      end
      OP_IALU: begin
        ctrl_o.valid = 1'b1; ctrl_o.alu_op = opcode_i;
        ctrl_o.rf_we = 1'b1; ctrl_o.rewr = REWR_ALU;
        ctrl_o.amux  = 1'b1; ctrl_o.bmux = BMUX_IMM;
        uses_rs1_o   = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.valid = 1'b1; ctrl_o.alu_op = opcode_i;
        ctrl_o.rf_we = 1'b1; ctrl_o.rewr = REWR_MEM;
        ctrl_o.amux  = 1'b1; ctrl_o.bmux = BMUX_IMM;
        uses_rs1_o   = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.valid = 1'b1; ctrl_o.alu_op = opcode_i;
        ctrl_o.wen   = 1'b0; ctrl_o.be   = 4'b1111;
        ctrl_o.amux  = 1'b1; ctrl_o.bmux = BMUX_IMM;
        uses_rs1_o   = 1'b1; uses_rs2_o  = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_o.valid = 1'b1; ctrl_o.alu_op = opcode_i;
        ctrl_o.amux  = 1'b0; ctrl_o.bmux = BMUX_IMM;
        uses_rs1_o   = 1'b1; uses_rs2_o  = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.valid = 1'b1; ctrl_o.alu_op = opcode_i;
        ctrl_o.rf_we = 1'b1; ctrl_o.rewr = REWR_ALU;
        ctrl_o.amux  = 1'b0; ctrl_o.bmux = BMUX_FOUR;
      end
      OP_JALR: begin
        ctrl_o.valid = 1'b1; ctrl_o.alu_op = opcode_i;
        ctrl_o.rf_we = 1'b1; ctrl_o.rewr = REWR_ALU;
        ctrl_o.amux  = 1'b0; ctrl_o.bmux = BMUX_FOUR;
        ctrl_o.is_jalr = 1'b1;
        uses_rs1_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined control and hazard unit for the 5-stage RV32I core
// Purpose: carry decoded control through EX/MEM/WB, resolve load-use stalls,
//          memory-latency freezes and taken-branch/jump flushes, count retirements.
// Ports:
//   CLK, RST (sync, active-high)
//   ID_VALID, ID_OPCODE, ID_RS1, ID_RS2, ID_RD   ID-stage instruction
//   EX_TAKEN                                     branch outcome of the EX instruction
//   EX_VALID, EX_ALU_OP, EX_AMUX, EX_BMUX, EX_IS_JALR   EX controls
//   MEM_WEN (active-low), MEM_BE                 MEM controls
//   WB_RF_WE, WB_REWR_MUX                        WB controls
//   PC_WR, IR_WR, FLUSH                          fetch/ID control (combinational)
//   NUM_INST                                     retired-instruction count
module pipe_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int NUMINST_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ID_VALID,
  input  logic [6:0]           ID_OPCODE,
  input  logic [4:0]           ID_RS1,
  input  logic [4:0]           ID_RS2,
  input  logic [4:0]           ID_RD,
  input  logic                 EX_TAKEN,
  output logic                 EX_VALID,
  output logic [6:0]           EX_ALU_OP,
  output logic                 EX_AMUX,
  output logic [1:0]           EX_BMUX,
  output logic                 EX_IS_JALR,
  output logic                 MEM_WEN,
  output logic [3:0]           MEM_BE,
  output logic                 WB_RF_WE,
  output logic [1:0]           WB_REWR_MUX,
  output logic                 PC_WR,
  output logic                 IR_WR,
  output logic                 FLUSH,
  output logic [NUMINST_W-1:0] NUM_INST
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  ctrl_t                id_ctrl;
  logic                 id_uses_rs1, id_uses_rs2;

  ctrl_t                ex_q, ex_d;
  logic [4:0]           ex_rd_q;
  logic                 mem_valid_q, mem_wen_q, mem_rf_we_q;
  logic [3:0]           mem_be_q;
  logic [1:0]           mem_rewr_q;
  logic                 wb_valid_q, wb_rf_we_q;
  logic [1:0]           wb_rewr_q;
  logic [1:0]           wait_q, wait_d;
  logic [NUMINST_W-1:0] num_q, num_d;

  logic mem_wait, flush, stall, ex_load, rs_hit;

  pipe_decode u_decode (
    .opcode_i   (ID_OPCODE),
    .ctrl_o     (id_ctrl),
    .uses_rs1_o (id_uses_rs1),
    .uses_rs2_o (id_uses_rs2)
  );

  always_comb begin
    mem_wait = (wait_q != 2'd0);
    // A freeze masks the flush: the EX instruction is not allowed to redirect
    // fetch until the pipe is moving again.
    flush = !mem_wait && ex_q.valid &&
            (((ex_q.alu_op == OP_BRANCH) && EX_TAKEN) ||
             (ex_q.alu_op == OP_JAL) || (ex_q.alu_op == OP_JALR));
    ex_load = ex_q.valid && (ex_q.alu_op == OP_LOAD) && (ex_rd_q != 5'd0);
    rs_hit  = (id_uses_rs1 && (ID_RS1 == ex_rd_q)) ||
              (id_uses_rs2 && (ID_RS2 == ex_rd_q));
    stall   = !mem_wait && !flush && ID_VALID && ex_load && rs_hit;

    ex_d = (ID_VALID && !flush && !stall) ? id_ctrl : BUBBLE;
    // Counter is armed by whatever memory op moves from EX into MEM this edge.
    wait_d = (ex_q.valid && ((ex_q.alu_op == OP_LOAD) || (ex_q.alu_op == OP_STORE)))
             ? WAIT_INIT : 2'd0;
    num_d = wb_valid_q ? num_q + {{(NUMINST_W-1){1'b0}}, 1'b1} : num_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q        <= BUBBLE;
      ex_rd_q     <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b1;
      mem_be_q    <= 4'd0;
      mem_rf_we_q <= 1'b0;
      mem_rewr_q  <= REWR_NONE;
      wb_valid_q  <= 1'b0;
      wb_rf_we_q  <= 1'b0;
      wb_rewr_q   <= REWR_NONE;
      wait_q      <= 2'd0;
      num_q       <= '0;
    end else if (mem_wait) begin
      wait_q <= wait_q - 2'd1;
    end else begin
      ex_q        <= ex_d;
      ex_rd_q     <= ID_RD;
      mem_valid_q <= ex_q.valid;
      mem_wen_q   <= ex_q.wen;
      mem_be_q    <= ex_q.be;
      mem_rf_we_q <= ex_q.rf_we;
      mem_rewr_q  <= ex_q.rewr;
      wb_valid_q  <= mem_valid_q;
      wb_rf_we_q  <= mem_rf_we_q;
      wb_rewr_q   <= mem_rewr_q;
      wait_q      <= wait_d;
      num_q       <= num_d;
    end
  end

  assign EX_VALID    = ex_q.valid;
  assign EX_ALU_OP   = ex_q.alu_op;
  assign EX_AMUX     = ex_q.amux;
  assign EX_BMUX     = ex_q.bmux;
  assign EX_IS_JALR  = ex_q.is_jalr;
  assign MEM_WEN     = mem_wen_q;
  assign MEM_BE      = mem_be_q;
  assign WB_RF_WE    = wb_rf_we_q;
  assign WB_REWR_MUX = wb_rewr_q;
  assign PC_WR       = !mem_wait && !stall;
  assign IR_WR       = !mem_wait && !stall;
  assign FLUSH       = flush;
  assign NUM_INST    = num_q;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipelined control and hazard unit for the 5-stage RV32I core. It decodes the ID-stage opcode and carries the control bundle through registered EX/MEM/WB stages. It also detects load-use hazards, freezes the pipe for multi-cycle data-memory accesses, kills wrong-path instructions on taken branches and jumps, and counts retired instructions. It sits between the IF/ID register and the datapath stage muxes.

## Interface
Parameters:
- MEM_LAT, 1: data-memory access latency in cycles (1..4) for loads and stores.
- NUMINST_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; single clock domain, all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ID_VALID  in  1  ID holds a real instruction.
- ID_OPCODE  in  7  opcode of the ID instruction.
- ID_RS1, ID_RS2, ID_RD  in  5 each  register fields of the ID instruction.
- EX_TAKEN  in  1  branch condition of the EX instruction; only meaningful when EX holds a BRANCH.
- EX_VALID  out  1  EX slot holds a live instruction.
- EX_ALU_OP  out  7  ALU operation select, equal to the opcode.
- EX_AMUX  out  1  A-operand select: 1 = register, 0 = PC.
- EX_BMUX  out  2  B-operand select: 00 = immediate, 01 = constant 4, 11 = rs2.
- EX_IS_JALR  out  1  EX instruction is JALR.
- MEM_WEN  out  1  active-low data-memory write enable.
- MEM_BE  out  4  byte enables.
- WB_RF_WE  out  1  register-file write enable.
- WB_REWR_MUX  out  2  writeback source: 01 = memory, 10 = ALU/link, 00/11 = none.
- PC_WR, IR_WR  out  1  PC and IF/ID register load enables.
- FLUSH  out  1  kill the IF and ID instructions.
- NUM_INST  out  NUMINST_W  count of retired instructions.

## Operation
- Decode, per opcode. Any other opcode decodes as a bubble (all writes off).
  - R 0110011: RF_WE=1, REWR=10, AMUX=1, BMUX=11.
  - I-ALU 0010011: RF_WE=1, REWR=10, AMUX=1, BMUX=00.
  - LOAD 0000011: RF_WE=1, REWR=01, AMUX=1, BMUX=00.
  - STORE 0100011: WEN=0, BE=1111, AMUX=1, BMUX=00.
  - BRANCH 1100011: AMUX=0, BMUX=00.
  - JAL 1101111: RF_WE=1, REWR=10, AMUX=0, BMUX=01.
  - JALR 1100111: as JAL, plus IS_JALR=1.
- A bubble has valid=0, RF_WE=0, MEM_WEN=1, MEM_BE=0 and REWR=00.
- Rs usage: R, STORE and BRANCH use rs1 and rs2; I-ALU, LOAD and JALR use rs1; JAL uses neither.
- Load-use stall: asserted when ID_VALID, EX is a valid LOAD, EX rd≠0, and a used rs equals EX rd.
  - PC_WR=IR_WR=0.
  - A bubble enters EX; EX moves on to MEM normally.
- Register x0 never triggers a stall.
- Memory wait: when a valid LOAD or STORE enters MEM, a wait counter loads MEM_LAT-1. While the counter is nonzero:
  - all stage registers hold;
  - PC_WR=IR_WR=0;
  - FLUSH=0;
  - NUM_INST holds.
- Flush: asserted when EX is valid and is (BRANCH and EX_TAKEN), JAL or JALR, and no memory wait is active.
  - FLUSH=1 for exactly one cycle.
  - The ID instruction enters EX as a bubble; PC_WR=1 to load the target.
- Priority: memory wait > flush > load-use stall. A flush cancels a simultaneous load-use stall.
- Retire: NUM_INST increments by 1 when the WB stage is valid and not frozen. It wraps modulo 2^NUMINST_W.

## Timing
- Reset: all stage valids=0 and NUM_INST=0, and every other output takes its bubble value: EX_ALU_OP=0, EX_AMUX=0, EX_BMUX=00, EX_IS_JALR=0, MEM_WEN=1, MEM_BE=0, WB_RF_WE=0, WB_REWR_MUX=00. Also FLUSH=0, PC_WR=IR_WR=1, and the wait counter=0.
- Reset mid-wait or mid-stall is dropped immediately; the next cycle behaves as after reset.
- Latency without hazards: ID decode appears at EX outputs 1 cycle later, MEM outputs 2 cycles later, WB outputs 3 cycles later.
- PC_WR, IR_WR and FLUSH are combinational from the current state and ID inputs, valid in the same cycle.
- MEM_LAT=1 gives a zero-length wait, so there is no freeze.

## Structure
- Shared package pipe_pkg holds:
  - opcode localparams;
  - the REWR_MUX and BMUX encodings;
  - a ctrl_t struct with fields valid, alu_op, amux, bmux, is_jalr, wen, be, rf_we and rewr;
  - the BUBBLE constant.
- Sub-module pipe_decode: purely combinational, opcode to ctrl_t plus the uses_rs1/uses_rs2 flags.

## Test plan
- Reset, then add;add;add with ID_VALID=1 and no hazards: PC_WR=1 throughout and NUM_INST=3 three cycles after the last issue.
- lw x5 followed by add x6,x5,x7: one cycle with PC_WR=0 and a bubble in EX. The same sequence with rd=x0 gives no stall.
- beq in EX with EX_TAKEN=1: FLUSH=1 for one cycle, the next EX_VALID=0, and the killed instruction never counts.
- MEM_LAT=3 and a store: MEM_WEN=0 held 3 cycles, PC_WR=0 for 2 cycles, NUM_INST frozen.
- A taken jal in EX while the ID instruction has a load-use hazard: FLUSH wins, PC_WR=1, no stall.
- NUMINST_W=4 with 17 retirements: NUM_INST=1.
